// File: rtl/password_prog.sv
// rtl/password_prog.sv - stored-password programming FSM (old / new / confirm entry)
module password_prog #(
  parameter logic [15:0] DEFAULT_PW = 16'h1234,
  parameter int          TIMEOUT    = 200
) (
  input  logic        CLK_Prog,
  input  logic        RST_Prog,
  input  logic        Change_Req_Prog,
  input  logic        Digit_Valid_Prog,
  input  logic [3:0]  Digit_Prog,
  input  logic        Admin_Lock_Prog,
  output logic [15:0] Reg_out_Prog,
  output logic        Busy_Prog,
  output logic        Done_Prog,
  output logic        Error_Prog,
  output logic [1:0]  Digit_Cnt_Prog
);

  typedef enum logic [1:0] {IDLE, GET_OLD, GET_NEW, GET_CONF} state_t;

  localparam logic [7:0] IDLE_LAST = 8'(TIMEOUT - 1);

  state_t      state;
  logic [11:0] phase_buf;
  logic [15:0] cand;
  logic [7:0]  idle_cnt;
  logic [15:0] word;

  // Only three nibbles are ever held; the fourth is consumed straight from Digit_Prog.
  assign word      = {phase_buf, Digit_Prog};
  assign Busy_Prog = (state != IDLE);

  always_ff @(posedge CLK_Prog) begin
    Done_Prog  <= 1'b0;
    Error_Prog <= 1'b0;
    if (!RST_Prog) begin
      state          <= IDLE;
      Reg_out_Prog   <= DEFAULT_PW;
      phase_buf      <= '0;
      cand           <= '0;
      idle_cnt       <= '0;
      Digit_Cnt_Prog <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (Change_Req_Prog && !Admin_Lock_Prog) begin
            state          <= GET_OLD;
            phase_buf      <= '0;
            Digit_Cnt_Prog <= '0;
            idle_cnt       <= '0;
          end
        end
        default: begin
          if (Admin_Lock_Prog) begin
            state          <= IDLE;
            Error_Prog     <= 1'b1;
            phase_buf      <= '0;
            Digit_Cnt_Prog <= '0;
            idle_cnt       <= '0;
          end else if (Digit_Valid_Prog) begin
            idle_cnt <= '0;
            if (Digit_Cnt_Prog == 2'd3) begin
              phase_buf      <= '0;
              Digit_Cnt_Prog <= '0;
              case (state)
                GET_OLD: begin
                  if (word == Reg_out_Prog) begin
                    state <= GET_NEW;
                  end else begin
                    state      <= IDLE;
                    Error_Prog <= 1'b1;
                  end
                end
                GET_NEW: begin
                  cand  <= word;
                  state <= GET_CONF;
                end
                GET_CONF: begin
                  state <= IDLE;
                  if (word == cand) begin
                    Reg_out_Prog <= cand;
                    Done_Prog    <= 1'b1;
                  end else begin
                    Error_Prog <= 1'b1;
                  end
                end
                default: state <= IDLE;
              endcase
            end else begin
              phase_buf      <= word[11:0];
              Digit_Cnt_Prog <= Digit_Cnt_Prog + 2'd1;
            end
          end else if (idle_cnt == IDLE_LAST) begin
            state          <= IDLE;
            Error_Prog     <= 1'b1;
            phase_buf      <= '0;
            Digit_Cnt_Prog <= '0;
            idle_cnt       <= '0;
          end else begin
            idle_cnt <= idle_cnt + 8'd1;
          end
        end
      endcase
    end
  end

endmodule

// File: doc/password_prog.md
PASSWORD_PROG -- requirements
Module: password_prog

Interface
REQ-001 The block SHALL have parameter DEFAULT_PW, default 16'h1234, meaning the stored password loaded on reset.
REQ-002 The block SHALL have parameter TIMEOUT, default 200, meaning idle cycles allowed between accepted digits (range 1..255).
REQ-003 The block SHALL have port CLK_Prog, input, 1 bit, the single clock; all logic on the rising edge.
REQ-004 The block SHALL have port RST_Prog, input, 1 bit, synchronous active-low reset.
REQ-005 The block SHALL have port Change_Req_Prog, input, 1 bit, a level sampled each cycle that requests a password-change session.
REQ-006 The block SHALL have port Digit_Valid_Prog, input, 1 bit, a strobe marking Digit_Prog valid for one cycle.
REQ-007 The block SHALL have port Digit_Prog, input, 4 bits, the keypad nibble (any value 0..F accepted).
REQ-008 The block SHALL have port Admin_Lock_Prog, input, 1 bit, which blocks or aborts a session while high.
REQ-009 The block SHALL have port Reg_out_Prog, output, 16 bits, the stored password feeding the comparator's Reg_in.
REQ-010 The block SHALL have port Busy_Prog, output, 1 bit, high whenever the state is not IDLE.
REQ-011 The block SHALL have port Done_Prog, output, 1 bit, a one-cycle pulse on a successful password write.
REQ-012 The block SHALL have port Error_Prog, output, 1 bit, a one-cycle pulse on a failed or aborted session.
REQ-013 The block SHALL have port Digit_Cnt_Prog, output, 2 bits, the number of digits collected in the current phase.

Function
REQ-014 The FSM SHALL have exactly these states: IDLE, GET_OLD, GET_NEW, GET_CONF.
REQ-015 In IDLE, Change_Req_Prog=1 with Admin_Lock_Prog=0 SHALL move the FSM to GET_OLD on the next edge; Digit_Valid_Prog SHALL be ignored in IDLE.
REQ-016 In every other state, Change_Req_Prog SHALL be ignored.
REQ-017 Each accepted digit SHALL shift into a 16-bit phase buffer MSB-first (buf <= {buf[11:0], Digit_Prog}) and increment Digit_Cnt_Prog; the 4th digit completes the phase.
REQ-018 The buffer and Digit_Cnt_Prog SHALL clear to 0 on every state entry.
REQ-019 GET_OLD completion: if the assembled word equals Reg_out_Prog, the FSM SHALL go to GET_NEW; otherwise it SHALL go to IDLE and pulse Error_Prog.
REQ-020 GET_NEW completion SHALL latch the word as the candidate and move the FSM to GET_CONF.
REQ-021 GET_CONF completion: if the word equals the candidate, the block SHALL, on that same sampling edge, load Reg_out_Prog with the candidate, pulse Done_Prog for one cycle, and return to IDLE.
REQ-022 GET_CONF completion with a mismatch SHALL return to IDLE, pulse Error_Prog, and leave Reg_out_Prog unchanged.
REQ-023 A timeout counter SHALL clear on state entry and on each accepted digit, and SHALL increment every other non-IDLE cycle.
REQ-024 On the TIMEOUT-th consecutive idle cycle, the FSM SHALL go to IDLE and pulse Error_Prog.
REQ-025 Admin_Lock_Prog=1 in any non-IDLE state SHALL force IDLE and pulse Error_Prog on the next edge, with no write.
REQ-026 Priority SHALL be reset > Admin_Lock_Prog > digit accept > timeout.
REQ-027 Done_Prog and Error_Prog SHALL never be high in the same cycle.
REQ-028 Reg_out_Prog SHALL change only on reset or on a successful REQ-021 write.

Reset
REQ-029 With RST_Prog=0 at an edge, the block SHALL set: state=IDLE, Reg_out_Prog=DEFAULT_PW, Busy_Prog=0, Done_Prog=0, Error_Prog=0, Digit_Cnt_Prog=0, buffer/candidate/timeout=0.
REQ-030 Reset mid-session SHALL discard the session and SHALL pulse neither Done_Prog nor Error_Prog.

Verification
REQ-031 Successful change: reset, Change_Req, then digits 1,2,3,4 / 5,6,7,8 / 5,6,7,8 -> Done_Prog=1 for one cycle after the last digit edge, Reg_out_Prog=16'h5678, Busy_Prog=0.
REQ-032 Wrong old password: Change_Req, then 1,2,3,5 -> Error_Prog pulse, state IDLE, Reg_out_Prog=16'h1234.
REQ-033 Confirm mismatch: old 1234, new 9ABC, confirm 9ABD -> Error_Prog pulse, Reg_out_Prog=16'h1234.
REQ-034 Timeout: TIMEOUT=10, Change_Req, digit 1, then no digits -> Error_Prog exactly 10 cycles after the digit edge; a digit arriving on cycle 9 resets the count.
REQ-035 Abort and reset: Admin_Lock_Prog=1 coincident with the 4th confirm digit -> Error_Prog, no write; RST_Prog=0 during GET_NEW -> no pulse, Reg_out_Prog=DEFAULT_PW.
REQ-036 Lock block: Admin_Lock_Prog=1 with Change_Req in IDLE -> Busy_Prog stays 0, no pulses.
